button_press_processor: RTL
===========================

Name: button_press_processor

Overview:
- Conditions a raw push-button input into the single-cycle `press_processed` strobe consumed by the pause/resume toggle FSM.
- Also provides a clean debounced level and a one-shot long-press strobe for reset/clear functions.
- Runs on the slow 100 Hz system tick. It sits between the board pin and the control FSMs.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change (4 = 40 ms); legal range 1..255.
- LONG_PRESS_CYCLES, 100, cycles after `press_processed` at which `long_press` fires (100 = 1 s); legal range 1..65535.

Ports:
- clk_100hz  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pb_in  input  1  raw, asynchronous, bouncing button; 1 = pressed.
- pb_debounced  output  1  debounced button level.
- press_processed  output  1  one-cycle pulse on each accepted press.
- long_press  output  1  one-cycle pulse when a press has been held LONG_PRESS_CYCLES.

Behaviour:
- Reset (rst=1, async): sync flops, debounce counter, hold counter, pb_debounced, press_processed and long_press all go to 0; FSM goes to IDLE. Outputs stay 0 while rst=1.
- Synchronizer: two flops, pb_in -> pb_s1 -> pb_sync. No logic between them.
- Debounce counter (8 bit):
  - Clears whenever pb_sync == pb_debounced.
  - Increments each cycle pb_sync != pb_debounced.
  - On a mismatch cycle with count == DEBOUNCE_CYCLES-1, pb_debounced toggles at that edge and the counter clears.
  - Any bounce back to the old level before that point clears the count, so no toggle occurs.
- Latency: pb_debounced rises/falls on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new pb_in level. This is 6 edges for the default.
- FSM states: IDLE, PRESSED, LONG_HELD.
  - IDLE: when pb_debounced rises (registered on the same edge), assert press_processed for exactly that one cycle, clear the hold counter, go to PRESSED.
  - PRESSED:
    - Hold counter (16 bit) increments each cycle.
    - When hold count == LONG_PRESS_CYCLES-1, assert long_press for one cycle and go to LONG_HELD. long_press is therefore high exactly LONG_PRESS_CYCLES cycles after the press_processed cycle.
    - If pb_debounced falls first, go to IDLE with no long_press.
  - LONG_HELD: no further pulses; hold counter frozen; go to IDLE when pb_debounced falls.
- Release takes priority over a coincident long-press threshold on the same edge: go to IDLE, no long_press.
- press_processed and long_press are never high in the same cycle. At most one of each is produced per press.
- Registered outputs only; no combinational path from pb_in to any output.
- Reset mid-press: all state is discarded. If pb_in is still high after reset release, it is re-debounced and press_processed fires (DEBOUNCE_CYCLES+2) edges after release.
- DEBOUNCE_CYCLES = 1: a level is accepted after a single mismatched pb_sync cycle (3-edge latency).

Test Plan:
- Clean press: reset, then pb_in 0->1 held 20 cycles with defaults -> pb_debounced and press_processed rise on the 6th edge; press_processed high 1 cycle only; long_press stays 0.
- Bounce rejection: pb_in toggles 1,0,1,0 with 2-cycle dwell each, then held 1 -> no pulse during bounce; exactly one press_processed, 6 edges after the final rise.
- Short glitch: pb_in high for 3 cycles then low -> pb_debounced, press_processed and long_press all stay 0.
- Long press: LONG_PRESS_CYCLES=10, hold pb_in high 40 cycles -> press_processed at edge 6, long_press at edge 16 for one cycle, nothing further. Release -> pb_debounced falls 6 edges later; FSM in IDLE.
- Release racing threshold: LONG_PRESS_CYCLES=10; time the release so pb_debounced falls on the edge where the hold count hits 9 -> no long_press; next press produces press_processed normally.
- Async reset mid-hold: assert rst for 3 cycles while in PRESSED with pb_in held 1 -> outputs 0 immediately. After release, press_processed fires again 6 edges later.

Source files
------------

// File: rtl/button_press_processor_if.sv
// Push-button conditioning bundle: raw pin level toward the conditioner,
// clean level and one-cycle event strobes back toward the control FSMs.
interface button_press_processor_if;
  logic pb_in;
  logic pb_debounced;
  logic press_processed;
  logic long_press;

  modport master (
    output pb_in,
    input  pb_debounced,
    input  press_processed,
    input  long_press
  );

  modport slave (
    input  pb_in,
    output pb_debounced,
    output press_processed,
    output long_press
  );
endinterface

// File: rtl/button_press_processor.sv
// Push-button conditioner on the 100 Hz tick: two-flop synchronizer, counter
// debouncer, and a press / long-press strobe FSM with registered outputs.
module button_press_processor #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 100
) (
  input  logic                     clk_100hz,
  input  logic                     rst,
  button_press_processor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(LONG_PRESS_CYCLES - 1);

  logic        pb_s1_r;
  logic        pb_sync_r;
  logic        pb_debounced_r;
  logic [7:0]  db_cnt_r;
  logic [15:0] hold_cnt_r;
  logic        press_processed_r;
  logic        long_press_r;
  state_t      state_r;

  logic mismatch_s;
  logic accept_s;
  logic rise_s;
  logic fall_s;

  // Level-change acceptance, shared by the debouncer and the FSM so both see the same edge.
  always_comb begin
    mismatch_s = (pb_sync_r != pb_debounced_r);
    accept_s   = mismatch_s && (db_cnt_r == DB_LAST);
    rise_s     = accept_s && !pb_debounced_r;
    fall_s     = accept_s && pb_debounced_r;
  end

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk_100hz or posedge rst) begin
    if (rst) begin
      pb_s1_r   <= 1'b0;
      pb_sync_r <= 1'b0;
    end else begin
      pb_s1_r   <= bus.pb_in;
      pb_sync_r <= pb_s1_r;
    end
  end

  // Debounce counter: any return to the accepted level restarts the count.
  always_ff @(posedge clk_100hz or posedge rst) begin
    if (rst) begin
      db_cnt_r       <= 8'd0;
      pb_debounced_r <= 1'b0;
    end else if (!mismatch_s) begin
      db_cnt_r <= 8'd0;
    end else if (accept_s) begin
      db_cnt_r       <= 8'd0;
      pb_debounced_r <= ~pb_debounced_r;
    end else begin
      db_cnt_r <= db_cnt_r + 8'd1;
    end
  end

  // Press / long-press FSM; release wins over a coincident long-press threshold.
  always_ff @(posedge clk_100hz or posedge rst) begin
    if (rst) begin
      state_r           <= IDLE;
      hold_cnt_r        <= 16'd0;
      press_processed_r <= 1'b0;
      long_press_r      <= 1'b0;
    end else begin
      press_processed_r <= 1'b0;
      long_press_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            press_processed_r <= 1'b1;
            hold_cnt_r        <= 16'd0;
            state_r           <= PRESSED;
          end else begin
            state_r <= IDLE;
          end
        end
        PRESSED: begin
          if (fall_s) begin
            state_r <= IDLE;
          end else if (hold_cnt_r == HOLD_LAST) begin
            long_press_r <= 1'b1;
            state_r      <= LONG_HELD;
          end else begin
            hold_cnt_r <= hold_cnt_r + 16'd1;
          end
        end
        LONG_HELD: begin
          if (fall_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= LONG_HELD;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.pb_debounced    = pb_debounced_r;
  assign bus.press_processed = press_processed_r;
  assign bus.long_press      = long_press_r;

endmodule
